// File: rtl/axi4_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axi4_pkg
// Description : Shared AXI4 encodings and master FSM state codes used by the
//               MMIO master and its peer slave peripherals.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_pkg;

  // Burst type: single-beat MMIO accesses always use INCR
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  // Response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Transfer size codes (bytes per beat = 2**size)
  localparam logic [2:0] AXI_SIZE_1B     = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B     = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B     = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B     = 3'd3;

  // Master state type and encodings
  typedef logic [2:0] mst_state_t;
  localparam mst_state_t ST_IDLE    = 3'd0;
  localparam mst_state_t ST_WR_REQ  = 3'd1;
  localparam mst_state_t ST_WR_RESP = 3'd2;
  localparam mst_state_t ST_RD_REQ  = 3'd3;
  localparam mst_state_t ST_RD_DATA = 3'd4;
  localparam mst_state_t ST_RSP     = 3'd5;

endpackage : axi4_pkg
`default_nettype wire

// File: rtl/axi4_mmio_master.sv
`default_nettype none
// ============================================================================
// Module      : axi4_mmio_master
// Description : Single-outstanding AXI4 initiator. Converts a command /
//               response handshake into one single-beat AXI4 read or write.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_mmio_master
  import axi4_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 31,
  parameter int DATA_W = 64,
  parameter int AXI_ID = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  // command / response interface
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  // write address channel
  output logic                  io_axi4_0_aw_valid,
  input  logic                  io_axi4_0_aw_ready,
  output logic [ID_W-1:0]       io_axi4_0_aw_id,
  output logic [ADDR_W-1:0]     io_axi4_0_aw_addr,
  output logic [7:0]            io_axi4_0_aw_len,
  output logic [2:0]            io_axi4_0_aw_size,
  output logic [1:0]            io_axi4_0_aw_burst,
  // write data channel
  output logic                  io_axi4_0_w_valid,
  input  logic                  io_axi4_0_w_ready,
  output logic [DATA_W-1:0]     io_axi4_0_w_data,
  output logic [DATA_W/8-1:0]   io_axi4_0_w_strb,
  output logic                  io_axi4_0_w_last,
  // write response channel
  input  logic                  io_axi4_0_b_valid,
  output logic                  io_axi4_0_b_ready,
  input  logic [ID_W-1:0]       io_axi4_0_b_id,
  input  logic [1:0]            io_axi4_0_b_resp,
  // read address channel
  output logic                  io_axi4_0_ar_valid,
  input  logic                  io_axi4_0_ar_ready,
  output logic [ID_W-1:0]       io_axi4_0_ar_id,
  output logic [ADDR_W-1:0]     io_axi4_0_ar_addr,
  output logic [7:0]            io_axi4_0_ar_len,
  output logic [2:0]            io_axi4_0_ar_size,
  output logic [1:0]            io_axi4_0_ar_burst,
  // read data channel
  input  logic                  io_axi4_0_r_valid,
  output logic                  io_axi4_0_r_ready,
  input  logic [ID_W-1:0]       io_axi4_0_r_id,
  input  logic [DATA_W-1:0]     io_axi4_0_r_data,
  input  logic [1:0]            io_axi4_0_r_resp,
  input  logic                  io_axi4_0_r_last,
  // status
  output logic                  busy
);

  localparam int STRB_W = DATA_W / 8;

  mst_state_t          state;
  logic                aw_valid_q;
  logic                w_valid_q;
  logic                ar_valid_q;
  logic                first_beat_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          size_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_q;

  // A channel is finished once its valid has dropped or it handshakes now
  logic aw_done;
  logic w_done;
  assign aw_done = !aw_valid_q || io_axi4_0_aw_ready;
  assign w_done  = !w_valid_q  || io_axi4_0_w_ready;

  // IDs are not checked: only one transaction is ever outstanding
  logic unused_ids;
  assign unused_ids = ^{io_axi4_0_b_id, io_axi4_0_r_id};

  // FSM, per-channel valid tracking and command/response capture
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      ar_valid_q   <= 1'b0;
      first_beat_q <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      resp_q       <= AXI_RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            write_q <= cmd_write;
            addr_q  <= cmd_addr;
            size_q  <= cmd_size;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            if (cmd_write) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state      <= ST_WR_REQ;
            end else begin
              ar_valid_q <= 1'b1;
              state      <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (aw_valid_q && io_axi4_0_aw_ready) aw_valid_q <= 1'b0;
          if (w_valid_q && io_axi4_0_w_ready)   w_valid_q  <= 1'b0;
          if (aw_done && w_done)                state      <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (io_axi4_0_b_valid) begin
            resp_q  <= io_axi4_0_b_resp;
            rdata_q <= '0;
            state   <= ST_RSP;
          end
        end
        ST_RD_REQ: begin
          if (io_axi4_0_ar_ready) begin
            ar_valid_q   <= 1'b0;
            first_beat_q <= 1'b1;
            state        <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          // Extra beats from a misbehaving slave are drained; only the
          // worst response survives, data comes from the first beat.
          if (io_axi4_0_r_valid) begin
            first_beat_q <= 1'b0;
            if (first_beat_q) begin
              rdata_q <= io_axi4_0_r_data;
              resp_q  <= io_axi4_0_r_resp;
            end else if (io_axi4_0_r_resp > resp_q) begin
              resp_q  <= io_axi4_0_r_resp;
            end
            if (io_axi4_0_r_last) state <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RSP);
  assign busy      = (state != ST_IDLE);
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

  assign io_axi4_0_aw_valid = aw_valid_q;
  assign io_axi4_0_aw_id    = ID_W'(AXI_ID);
  assign io_axi4_0_aw_addr  = addr_q;
  assign io_axi4_0_aw_len   = 8'd0;
  assign io_axi4_0_aw_size  = size_q;
  assign io_axi4_0_aw_burst = AXI_BURST_INCR;

  assign io_axi4_0_w_valid  = w_valid_q;
  assign io_axi4_0_w_data   = wdata_q;
  assign io_axi4_0_w_strb   = wstrb_q;
  assign io_axi4_0_w_last   = 1'b1;

  assign io_axi4_0_b_ready  = (state == ST_WR_RESP);

  assign io_axi4_0_ar_valid = ar_valid_q;
  assign io_axi4_0_ar_id    = ID_W'(AXI_ID);
  assign io_axi4_0_ar_addr  = addr_q;
  assign io_axi4_0_ar_len   = 8'd0;
  assign io_axi4_0_ar_size  = size_q;
  assign io_axi4_0_ar_burst = AXI_BURST_INCR;

  assign io_axi4_0_r_ready  = (state == ST_RD_DATA);

endmodule : axi4_mmio_master
`default_nettype wire

// File: tb/tb_axi4_mmio_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_mmio_master
// Description : Directed self-checking bench for axi4_mmio_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_mmio_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [30:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [63:0] cmd_wdata;
  logic [7:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        aw_valid, aw_ready;
  logic [3:0]  aw_id;
  logic [30:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        w_valid, w_ready, w_last;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid, b_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_id;
  logic [30:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready, r_last;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;
  int aw_hs   = 0;
  int w_hs    = 0;

  always #5 clock = ~clock;

  // Handshake counters observed at the active edge
  always @(posedge clock) begin
    if (aw_valid && aw_ready) aw_hs <= aw_hs + 1;
    if (w_valid && w_ready)   w_hs  <= w_hs + 1;
  end

  axi4_mmio_master #(.ID_W(4), .ADDR_W(31), .DATA_W(64), .AXI_ID(0)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .io_axi4_0_aw_valid(aw_valid), .io_axi4_0_aw_ready(aw_ready),
    .io_axi4_0_aw_id(aw_id), .io_axi4_0_aw_addr(aw_addr),
    .io_axi4_0_aw_len(aw_len), .io_axi4_0_aw_size(aw_size),
    .io_axi4_0_aw_burst(aw_burst),
    .io_axi4_0_w_valid(w_valid), .io_axi4_0_w_ready(w_ready),
    .io_axi4_0_w_data(w_data), .io_axi4_0_w_strb(w_strb),
    .io_axi4_0_w_last(w_last),
    .io_axi4_0_b_valid(b_valid), .io_axi4_0_b_ready(b_ready),
    .io_axi4_0_b_id(b_id), .io_axi4_0_b_resp(b_resp),
    .io_axi4_0_ar_valid(ar_valid), .io_axi4_0_ar_ready(ar_ready),
    .io_axi4_0_ar_id(ar_id), .io_axi4_0_ar_addr(ar_addr),
    .io_axi4_0_ar_len(ar_len), .io_axi4_0_ar_size(ar_size),
    .io_axi4_0_ar_burst(ar_burst),
    .io_axi4_0_r_valid(r_valid), .io_axi4_0_r_ready(r_ready),
    .io_axi4_0_r_id(r_id), .io_axi4_0_r_data(r_data),
    .io_axi4_0_r_resp(r_resp), .io_axi4_0_r_last(r_last),
    .busy(busy)
  );

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [30:0] a, input logic [2:0] sz,
                       input logic [63:0] d, input logic [7:0] s);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
    cmd_size  = sz;   cmd_wdata = d;  cmd_wstrb = s;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_total++;
    if ({cmd_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, busy} !== 8'b1000_0000) begin
      $display("FAIL reset_ctrl: got %b want 10000000",
               {cmd_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, busy});
    end else n_pass++;
    n_total++;
    if ({rsp_rdata, rsp_resp, rsp_write} !== 67'd0) begin
      $display("FAIL reset_rsp: rdata=%h resp=%0d write=%b want 0", rsp_rdata, rsp_resp, rsp_write);
    end else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_min();
    aw_ready = 1'b1; w_ready = 1'b1;
    issue(1'b1, 31'h6000_0004, 3'd0, 64'h41, 8'h01);        // cycle 0
    tick(); cmd_valid = 1'b0;                                // cycle 1
    n_total++;
    if ({aw_valid, w_valid, aw_len, aw_burst, w_last, aw_id, aw_addr, w_data, w_strb}
        !== {1'b1, 1'b1, 8'd0, 2'b01, 1'b1, 4'd0, 31'h6000_0004, 64'h41, 8'h01}) begin
      $display("FAIL wr_min_req: awv=%b wv=%b len=%0d burst=%0d last=%b id=%0d addr=%h data=%h strb=%h",
               aw_valid, w_valid, aw_len, aw_burst, w_last, aw_id, aw_addr, w_data, w_strb);
    end else n_pass++;
    tick();                                                  // cycle 2
    n_total++;
    if ({aw_valid, w_valid, b_ready, rsp_valid} !== 4'b0010) begin
      $display("FAIL wr_min_bready: got %b want 0010", {aw_valid, w_valid, b_ready, rsp_valid});
    end else n_pass++;
    b_valid = 1'b1; b_resp = 2'd0;
    tick(); b_valid = 1'b0;                                  // cycle 3
    n_total++;
    if ({rsp_valid, rsp_resp, rsp_write, b_ready} !== 5'b1_00_1_0 || rsp_rdata !== 64'd0) begin
      $display("FAIL wr_min_rsp: valid=%b resp=%0d write=%b bready=%b rdata=%h want 1/0/1/0/0",
               rsp_valid, rsp_resp, rsp_write, b_ready, rsp_rdata);
    end else n_pass++;
    rsp_ready = 1'b1;
    tick(); rsp_ready = 1'b0;
    n_total++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      $display("FAIL wr_min_idle: rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
    end else n_pass++;
  endtask

  task automatic test_write_skew();
    int aw0, w0, bad;
    aw0 = aw_hs; w0 = w_hs; bad = 0;
    aw_ready = 1'b0; w_ready = 1'b1;
    issue(1'b1, 31'h6000_0008, 3'd3, 64'h1122_3344_5566_7788, 8'hFF);
    tick(); cmd_valid = 1'b0;                                // cycle 1: w handshake
    for (int c = 2; c <= 4; c++) begin
      tick();
      if (c == 4) aw_ready = 1'b1;
      if ({aw_valid, w_valid, b_ready} !== 3'b100) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL wr_skew_hold: %0d bad cycles want 0", bad);
    else n_pass++;
    tick(); aw_ready = 1'b0;                                 // cycle 5
    n_total++;
    if ({aw_valid, w_valid, b_ready} !== 3'b001) begin
      $display("FAIL wr_skew_bready: got %b want 001", {aw_valid, w_valid, b_ready});
    end else n_pass++;
    b_valid = 1'b1; b_resp = 2'd2;
    tick(); b_valid = 1'b0;                                  // cycle 6
    n_total++;
    if ({rsp_valid, rsp_resp, rsp_write} !== 4'b1_10_1) begin
      $display("FAIL wr_skew_rsp: valid=%b resp=%0d write=%b want 1/2/1", rsp_valid, rsp_resp, rsp_write);
    end else n_pass++;
    n_total++;
    if ((aw_hs - aw0) != 1 || (w_hs - w0) != 1) begin
      $display("FAIL wr_skew_count: aw=%0d w=%0d want 1/1", aw_hs - aw0, w_hs - w0);
    end else n_pass++;
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_read_wait();
    ar_ready = 1'b1;
    issue(1'b0, 31'h6000_0000, 3'd3, 64'h0, 8'h0);
    tick(); cmd_valid = 1'b0;                                // cycle 1
    n_total++;
    if ({ar_valid, ar_len, ar_burst, ar_id, ar_addr, ar_size, aw_valid}
        !== {1'b1, 8'd0, 2'b01, 4'd0, 31'h6000_0000, 3'd3, 1'b0}) begin
      $display("FAIL rd_req: arv=%b len=%0d burst=%0d id=%0d addr=%h size=%0d awv=%b",
               ar_valid, ar_len, ar_burst, ar_id, ar_addr, ar_size, aw_valid);
    end else n_pass++;
    tick(); ar_ready = 1'b0;                                 // cycle 2..5 wait
    tick(); tick(); tick();
    n_total++;
    if ({ar_valid, r_ready, rsp_valid} !== 3'b010) begin
      $display("FAIL rd_wait: got %b want 010", {ar_valid, r_ready, rsp_valid});
    end else n_pass++;
    tick();                                                  // cycle 6
    r_valid = 1'b1; r_data = 64'hDEAD_BEEF_0000_0055; r_resp = 2'd0; r_last = 1'b1;
    tick(); r_valid = 1'b0; r_last = 1'b0;                   // cycle 7
    n_total++;
    if ({rsp_valid, rsp_resp, rsp_write, r_ready} !== 5'b1_00_0_0 || rsp_rdata !== 64'hDEAD_BEEF_0000_0055) begin
      $display("FAIL rd_rsp: valid=%b resp=%0d write=%b rready=%b rdata=%h want 1/0/0/0/deadbeef00000055",
               rsp_valid, rsp_resp, rsp_write, r_ready, rsp_rdata);
    end else n_pass++;
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_read_multibeat();
    ar_ready = 1'b1;
    issue(1'b0, 31'h6000_0010, 3'd2, 64'h0, 8'h0);
    tick(); cmd_valid = 1'b0;                                // cycle 1
    tick(); ar_ready = 1'b0;                                 // cycle 2
    r_valid = 1'b1; r_data = 64'hAAAA_0000_0000_0001; r_resp = 2'd0; r_last = 1'b0;
    tick();                                                  // cycle 3
    n_total++;
    if ({r_ready, rsp_valid} !== 2'b10) begin
      $display("FAIL rd_multi_drain: rready=%b rsp_valid=%b want 1/0", r_ready, rsp_valid);
    end else n_pass++;
    r_data = 64'hBBBB_0000_0000_0002; r_resp = 2'd2; r_last = 1'b1;
    tick(); r_valid = 1'b0; r_last = 1'b0;                   // cycle 4
    n_total++;
    if ({rsp_valid, rsp_resp} !== 3'b1_10 || rsp_rdata !== 64'hAAAA_0000_0000_0001) begin
      $display("FAIL rd_multi_rsp: valid=%b resp=%0d rdata=%h want 1/2/aaaa000000000001",
               rsp_valid, rsp_resp, rsp_rdata);
    end else n_pass++;
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL rd_multi_single: rsp_valid=%b want 0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    aw_ready = 1'b1; w_ready = 1'b1;
    issue(1'b1, 31'h6000_000C, 3'd1, 64'h0000_BEEF, 8'h03);
    tick(); cmd_valid = 1'b0;
    tick(); b_valid = 1'b1; b_resp = 2'd1;
    tick(); b_valid = 1'b0;                                  // in RSP
    for (int c = 0; c < 5; c++) begin
      if ({rsp_valid, cmd_ready, rsp_resp, rsp_write} !== 5'b1_0_01_1 || rsp_rdata !== 64'd0) bad++;
      tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL bp_stable: %0d bad cycles want 0", bad);
    else n_pass++;
    rsp_ready = 1'b1;
    ar_ready = 1'b1;
    issue(1'b0, 31'h6000_0020, 3'd2, 64'h0, 8'h0);           // presented during handshake
    tick(); rsp_ready = 1'b0;
    n_total++;
    if ({cmd_ready, rsp_valid, ar_valid, aw_valid} !== 4'b1000) begin
      $display("FAIL bp_no_early_accept: got %b want 1000", {cmd_ready, rsp_valid, ar_valid, aw_valid});
    end else n_pass++;
    tick(); cmd_valid = 1'b0;
    n_total++;
    if ({ar_valid, cmd_ready} !== 2'b10 || ar_addr !== 31'h6000_0020) begin
      $display("FAIL b2b_accept: arv=%b cmd_ready=%b addr=%h want 1/0/60000020", ar_valid, cmd_ready, ar_addr);
    end else n_pass++;
    tick(); ar_ready = 1'b0;
    r_valid = 1'b1; r_data = 64'h77; r_resp = 2'd0; r_last = 1'b1;
    tick(); r_valid = 1'b0; r_last = 1'b0;
    n_total++;
    if ({rsp_valid, rsp_write} !== 2'b10 || rsp_rdata !== 64'h77) begin
      $display("FAIL b2b_rsp: valid=%b write=%b rdata=%h want 1/0/77", rsp_valid, rsp_write, rsp_rdata);
    end else n_pass++;
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    aw_ready = 1'b1; w_ready = 1'b1;
    issue(1'b1, 31'h6000_0004, 3'd0, 64'h5A, 8'h01);
    tick(); cmd_valid = 1'b0;
    tick();                                                  // WR_RESP
    n_total++;
    if (b_ready !== 1'b1) $display("FAIL rst_mid_pre: b_ready=%b want 1", b_ready);
    else n_pass++;
    b_valid = 1'b1; b_resp = 2'd0; reset = 1'b1;
    tick();
    n_total++;
    if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, cmd_ready, busy} !== 8'b0000_0010) begin
      $display("FAIL rst_mid: got %b want 00000010",
               {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, cmd_ready, busy});
    end else n_pass++;
    reset = 1'b0; b_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_size = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_id = 4'd5; b_resp = '0;
    ar_ready = 1'b0; r_valid = 1'b0; r_id = 4'd7; r_data = '0; r_resp = '0; r_last = 1'b0;
    #2;
    test_reset();
    test_write_min();
    test_write_skew();
    test_read_wait();
    test_read_multibeat();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_axi4_mmio_master
`default_nettype wire
